cnn_frame_seq: RTL

CNN_FRAME_SEQ -- requirements
Module: cnn_frame_seq

---
 rtl/cnn_pkg.sv | 14 +
 rtl/cnn_frame_seq.sv | 116 +++++++++++
 2 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM encoding and default frame/timeout sizes for cnn_frame_seq
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    localparam int NUM_PIX_DEF = 784;
    localparam int TIMEOUT_DEF = 4096;

endpackage

// File: rtl/cnn_frame_seq.sv
// cnn_frame_seq: streams one image frame from pixel memory into a CNN and captures its class decision
//   clk, rst_n               clock, asynchronous active-low reset
//   start, abort             begin a frame (IDLE only) / cancel the current frame
//   busy                     high whenever not IDLE
//   mem_rd, mem_addr         pixel memory read strobe and address
//   mem_rdata                pixel data, valid one cycle after mem_rd
//   cnn_in_val, cnn_data_in  pixel stream to the CNN
//   cnn_out_val              CNN result strobe, honoured only while waiting
//   cnn_decision             CNN class result
//   result, result_valid     latched decision and its one-cycle update pulse
//   timeout_err              one-cycle pulse when the CNN never answered
module cnn_frame_seq
    import cnn_pkg::*;
#(
    parameter int NUM_PIX = NUM_PIX_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       mem_rd,
    output logic [9:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       cnn_in_val,
    output logic [7:0] cnn_data_in,
    input  logic       cnn_out_val,
    input  logic [3:0] cnn_decision,
    output logic [3:0] result,
    output logic       result_valid,
    output logic       timeout_err
);

    localparam int         CW        = $clog2(TIMEOUT + 1);
    localparam logic [9:0] LAST_ADDR = 10'(NUM_PIX - 1);

    state_e        state_q, state_d;
    logic [9:0]    addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          in_val_q, in_val_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    result_q, result_d;
    logic          rv_q, rv_d;
    logic          to_q, to_d;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rv_d     = 1'b0;
        to_d     = 1'b0;
        cnt_inc  = cnt_q + 1'b1;
        case (state_q)
            ST_IDLE:  if (start && !abort) state_d = ST_FETCH;
            ST_FETCH: begin
                if (abort) state_d = ST_IDLE;
                else if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = abort ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                // abort beats a result, and a result beats a timeout landing on the same cycle
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnn_out_val) begin
                    result_d = cnn_decision;
                    rv_d     = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    to_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // address only advances while staying in FETCH, so it reads 0 everywhere else
        addr_d   = (state_q == ST_FETCH && state_d == ST_FETCH) ? addr_q + 10'd1 : 10'd0;
        // cleared in every other state, so WAIT always starts counting from zero
        cnt_d    = (state_q == ST_WAIT) ? cnt_inc : '0;
        // a read in flight when abort hits never reaches the CNN
        in_val_d = mem_rd && !abort;
        data_d   = in_val_q ? mem_rdata : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            in_val_q <= 1'b0;
            data_q   <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            in_val_q <= in_val_d;
            data_q   <= data_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            to_q     <= to_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign mem_rd       = (state_q == ST_FETCH);
    assign mem_addr     = addr_q;
    assign cnn_in_val   = in_val_q;
    // memory data arrives in the cycle after the read, passed straight through and held afterwards
    assign cnn_data_in  = in_val_q ? mem_rdata : data_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign timeout_err  = to_q;

endmodule
